icache_fill_fsm: RTL and testbench

Miss-handling state machine for the instruction cache that feeds the fetch stage. On a fetch miss it stalls fetch, streams one whole cache block from the multi-cycle main memory, and writes each returned word into the data array. It writes the tag once the last word lands, then releases the stall. It sits between the fetch stage's instruction cache and the shared main-memory port.

---
 rtl/icache_fill_fsm.sv | 103 ++++++++++
 tb/tb_icache_fill_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: stalls fetch, streams one cache block from
// main memory into the data array, writes the tag with the last word, and
// then releases the stall.
module icache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] fill_addr
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] WORDS    = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST     = CW'(BLOCK_WORDS - 1);
  localparam logic [15:0]   OFF_MASK = 16'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t          state, state_n;
  logic [15:0]     base, base_n;
  logic [CW-1:0]   issue_cnt, issue_n;
  logic [CW-1:0]   recv_cnt, recv_n;
  logic [15:0]     issue_off, recv_off;

  // Word counters scaled to byte offsets; always stay inside the block.
  always_comb begin
    issue_off = 16'({issue_cnt, 1'b0});
    recv_off  = 16'({recv_cnt, 1'b0});
  end

  // State, block base and request/return counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_n;
      base      <= base_n;
      issue_cnt <= issue_n;
      recv_cnt  <= recv_n;
    end
  end

  // Next-state and output decode; issuing and receiving run independently.
  always_comb begin
    state_n          = state;
    base_n           = base;
    issue_n          = issue_cnt;
    recv_n           = recv_cnt;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_addr        = '0;

    unique case (state)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_n = FILL;
          base_n  = miss_address & ~OFF_MASK;
          issue_n = '0;
          recv_n  = '0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < WORDS) begin
          mem_en   = 1'b1;
          mem_addr = base + issue_off;
          issue_n  = issue_cnt + CW'(1);
        end
        if (memory_data_valid && (recv_cnt < WORDS)) begin
          write_data_array = 1'b1;
          fill_addr        = base + recv_off;
          recv_n           = recv_cnt + CW'(1);
          if (recv_cnt == LAST) begin
            write_tag_array = 1'b1;
            state_n         = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Self-checking bench for icache_fill_fsm: directed scenarios plus random
// traffic, checked against a queue-based model of the block fill.
module tb_icache_fill_fsm;

  localparam int unsigned BW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [15:0] mem_addr, fill_addr;

  logic        rst2 = 1'b1;
  logic        miss2 = 1'b0;
  logic [15:0] addr2 = '0;
  logic        valid2 = 1'b0;
  logic        busy2, en2, wda2, wta2;
  logic [15:0] maddr2, faddr2;

  icache_fill_fsm #(.BLOCK_WORDS(BW)) u_dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected),
    .miss_address(miss_address), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_en(mem_en), .mem_addr(mem_addr),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .fill_addr(fill_addr)
  );

  icache_fill_fsm #(.BLOCK_WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst2), .miss_detected(miss2),
    .miss_address(addr2), .memory_data_valid(valid2),
    .fsm_busy(busy2), .mem_en(en2), .mem_addr(maddr2),
    .write_data_array(wda2), .write_tag_array(wta2),
    .fill_addr(faddr2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a fill is a list of request addresses and a list of
  // write addresses; each is consumed in order.
  bit          m_fill = 1'b0;
  logic [15:0] req_q[$];
  logic [15:0] wr_q[$];
  // Memory model: cycle numbers at which outstanding requests may return.
  int          due_q[$];
  int          lat = 4;
  int          gap = 0;
  int          spur_pct = 0;
  int          last_v = -100;
  int          cyc_n = 0;

  // Observed statistics, cleared per scenario.
  int          n_busy, n_cyc, n_req, n_wr, n_tag;
  logic [15:0] first_req, last_req, tag_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_busy = 0; n_cyc = 0; n_req = 0; n_wr = 0; n_tag = 0;
    first_req = '0; last_req = '0; tag_addr = '0;
  endtask

  task automatic start_fill(input logic [15:0] a);
    int unsigned base;
    base = int'(a) - (int'(a) % (2 * BW));
    m_fill = 1'b1;
    req_q.delete();
    wr_q.delete();
    for (int unsigned i = 0; i < BW; i++) begin
      req_q.push_back(16'(base + 2 * i));
      wr_q.push_back(16'(base + 2 * i));
    end
  endtask

  task automatic tick(input bit r, input bit m, input logic [15:0] a);
    bit          v;
    bit          e_busy, e_en, e_wr, e_tag;
    logic [15:0] e_maddr, e_faddr;
    @(negedge clk);
    if (m_fill && req_q.size() != 0) due_q.push_back(cyc_n + lat);
    v = 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc_n && (cyc_n - last_v) > gap) begin
      v = 1'b1;
      void'(due_q.pop_front());
      last_v = cyc_n;
    end else if (spur_pct != 0 && $urandom_range(0, 99) < spur_pct) begin
      v = 1'b1;
    end
    rst = r; miss_detected = m; miss_address = a; memory_data_valid = v;

    e_busy = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_tag = 1'b0;
    e_maddr = '0; e_faddr = '0;
    if (m_fill) begin
      e_busy = 1'b1;
      if (req_q.size() != 0) begin
        e_en = 1'b1;
        e_maddr = req_q.pop_front();
      end
      if (v && wr_q.size() != 0) begin
        e_wr = 1'b1;
        e_faddr = wr_q.pop_front();
        e_tag = (wr_q.size() == 0);
      end
    end else begin
      e_busy = m;
    end

    #1;
    chk("fsm_busy", fsm_busy, e_busy);
    chk("mem_en", mem_en, e_en);
    chk("mem_addr", mem_addr, e_maddr);
    chk("write_data_array", write_data_array, e_wr);
    chk("write_tag_array", write_tag_array, e_tag);
    chk("fill_addr", fill_addr, e_faddr);

    n_cyc++;
    if (fsm_busy) n_busy++;
    if (mem_en) begin
      n_req++;
      if (n_req == 1) first_req = mem_addr;
      last_req = mem_addr;
    end
    if (write_data_array) n_wr++;
    if (write_tag_array) begin
      n_tag++;
      tag_addr = fill_addr;
    end

    if (r) begin
      m_fill = 1'b0;
      req_q.delete(); wr_q.delete(); due_q.delete();
    end else if (!m_fill && m) begin
      start_fill(a);
    end else if (m_fill && e_tag) begin
      m_fill = 1'b0;
    end
    cyc_n++;
  endtask

  // mode 0: miss low during fill, 1: held high, 2: toggling.
  task automatic run_fill(input int mode, input logic [15:0] a0, input logic [15:0] a_fill);
    int k;
    tick(1'b0, 1'b1, a0);
    k = 0;
    while (m_fill && k < 200) begin
      tick(1'b0, (mode == 1) ? 1'b1 : (mode == 2) ? bit'(k % 2) : 1'b0, a_fill);
      k++;
    end
    chk("fill_completes", {31'b0, m_fill}, 32'd0);
  endtask

  task automatic tick2(input bit r, input bit m, input logic [15:0] a, input bit v,
                       input bit e_busy, input bit e_en, input logic [15:0] e_maddr,
                       input bit e_wr, input bit e_tag, input logic [15:0] e_faddr);
    @(negedge clk);
    rst2 = r; miss2 = m; addr2 = a; valid2 = v;
    #1;
    chk("bw2_busy", busy2, e_busy);
    chk("bw2_mem_en", en2, e_en);
    chk("bw2_mem_addr", maddr2, e_maddr);
    chk("bw2_wda", wda2, e_wr);
    chk("bw2_wta", wta2, e_tag);
    chk("bw2_fill_addr", faddr2, e_faddr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clr_stats();

    // Reset with all inputs low.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);

    // Basic fill with a 4-cycle memory.
    lat = 4; gap = 0; clr_stats();
    run_fill(0, 16'h1236, 16'h0000);
    chk("basic_busy_cycles", n_busy, 13);
    chk("basic_requests", n_req, BW);
    chk("basic_first_req", first_req, 16'h1230);
    chk("basic_last_req", last_req, 16'h123E);
    chk("basic_writes", n_wr, BW);
    chk("basic_tags", n_tag, 1);
    chk("basic_tag_addr", tag_addr, 16'h123E);
    tick(1'b0, 1'b0, 16'h0000);

    // Gapped returns: two idle cycles between valids.
    lat = 4; gap = 2; clr_stats();
    run_fill(0, 16'h1236, 16'h0000);
    chk("gap_busy_cycles", n_busy, 27);
    chk("gap_writes", n_wr, BW);
    chk("gap_tags", n_tag, 1);
    gap = 0;
    tick(1'b0, 1'b0, 16'h0000);

    // Spurious valids in IDLE, then miss toggled during FILL.
    spur_pct = 50; clr_stats();
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0000);
    chk("idle_valid_writes", n_wr, 0);
    spur_pct = 0; clr_stats();
    run_fill(2, 16'h1236, 16'hBEEF);
    chk("toggle_first_req", first_req, 16'h1230);
    chk("toggle_last_req", last_req, 16'h123E);
    chk("toggle_tag_addr", tag_addr, 16'h123E);
    tick(1'b0, 1'b0, 16'h0000);

    // Back-to-back misses with miss held high.
    lat = 2; clr_stats();
    tick(1'b0, 1'b1, 16'h4444);
    k = 0;
    while (n_tag < 2 && k < 100) begin
      tick(1'b0, 1'b1, 16'h4444);
      k++;
    end
    chk("b2b_tags", n_tag, 2);
    chk("b2b_busy_all_cycles", n_busy, n_cyc);
    chk("b2b_tag_addr", tag_addr, 16'h444E);
    clr_stats();
    tick(1'b0, 1'b0, 16'h0000);
    chk("b2b_idle_after", n_busy, 0);

    // Top-of-memory block, zero-latency memory.
    lat = 0; clr_stats();
    run_fill(0, 16'hFFFE, 16'h0000);
    chk("top_first_req", first_req, 16'hFFF0);
    chk("top_last_req", last_req, 16'hFFFE);
    chk("top_tag_addr", tag_addr, 16'hFFFE);
    chk("top_busy_cycles", n_busy, BW + 1);
    tick(1'b0, 1'b0, 16'h0000);

    // Reset in the middle of a fill after three returned words.
    lat = 1; clr_stats();
    tick(1'b0, 1'b1, 16'h1236);
    k = 0;
    while (n_wr < 3 && k < 50) begin
      tick(1'b0, 1'b0, 16'h0000);
      k++;
    end
    chk("abort_writes_before_rst", n_wr, 3);
    tick(1'b1, 1'b0, 16'h0000);
    clr_stats();
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    chk("abort_busy_after", n_busy, 0);
    chk("abort_no_tag", n_tag, 0);

    // Random traffic: misses, addresses, latencies, gaps, stray valids, resets.
    spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        lat = int'($urandom_range(0, 6));
        gap = int'($urandom_range(0, 2));
      end
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 16'($urandom));
    end
    spur_pct = 0;

    // BLOCK_WORDS=2 instance at the top of memory.
    tick2(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick2(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick2(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b0, 1'b0, 16'h0000);
    tick2(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'hFFFC);
    tick2(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE);
    tick2(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
